flop_pipe: RTL and testbench
============================

Name: flop_pipe

Overview:
- Parametrised successor to the basic dual D-flop stage: CHANNELS lanes of WIDTH bits carried through DEPTH register stages.
- Adds synchronous reset, per-stage valid tracking, valid/ready backpressure with bubble collapsing, synchronous flush and an occupancy count.
- Used wherever datapath signals need retiming across several cycles while remaining stallable by a downstream consumer.

Parameters:
- WIDTH, 8, bits per channel (>=1)
- CHANNELS, 2, number of parallel lanes sharing one valid (>=1)
- DEPTH, 3, number of register stages (>=1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline clear
- in_valid  input  1  upstream word present on d
- in_ready  output  1  pipe accepts d this cycle
- d  input  CHANNELS*WIDTH  input lanes; lane k = d[k*WIDTH +: WIDTH]
- out_valid  output  1  q holds a valid word
- out_ready  input  1  downstream consumes q this cycle
- q  output  CHANNELS*WIDTH  output lanes, same packing as d
- count  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- State: per stage i (0..DEPTH-1), a valid bit v[i] and a data register r[i]. Stage 0 is the input side; stage DEPTH-1 drives q/out_valid.
- Reset: at a clk edge with reset=1:
  - all v[i]=0 and all r[i]=0;
  - out_valid=0, q=0, count=0.
  - in_ready=0 while reset is high.
  - reset overrides flush and any handshake.
- Advance rule, combinational, evaluated from the output back:
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - adv[i] = v[i] & (!v[i+1] | adv[i+1]).
- Load rule: stage i+1 loads r[i] and sets v[i+1]=1 when adv[i]. A stage that advances and is not reloaded clears its valid.
- Bubble collapsing: an empty stage always accepts from the stage before it, even if downstream is stalled. Gaps therefore close while out_ready=0.
- Input handshake:
  - in_ready = !reset & !flush & (!v[0] | adv[0]).
  - A transfer occurs when in_valid & in_ready: r[0]<=d, v[0]<=1.
  - in_ready depends combinationally on out_ready. This path is accepted and documented.
- Holding: a valid stage that does not advance holds r[i] and v[i] unchanged. Output q and out_valid are stable while out_valid=1 & out_ready=0.
- Invalid stages: data registers are loaded only with the valid bit; contents of invalid stages are not updated.
- Latency: with out_ready held at 1 and an empty pipe, a word accepted at edge n appears on q with out_valid=1 after edge n+DEPTH-1, i.e. DEPTH cycles input-to-output. Sustained throughput is one word per cycle.
- Simultaneous accept/consume:
  - A full pipe with out_ready=1 accepts a new word the same cycle (in_ready=1).
  - count is unchanged when an input transfer and an output transfer happen on the same edge.
- count:
  - +1 on an input transfer only; -1 on an output transfer only.
  - Always equals popcount(v). Range 0..DEPTH, never wraps.
- Flush (flush=1, reset=0):
  - at the edge, all v[i]<=0 and count<=0; data registers are unchanged.
  - in_ready=0 during the flush cycle, so an input offered that cycle is not taken.
  - out_valid still shows the pre-flush state during the flush cycle. The word present there counts as consumed if out_ready=1.
- Reset mid-stream: in-flight words are discarded. The first post-reset input obeys the full DEPTH latency.
- DEPTH=1: single stage, in_ready = !v[0] | out_ready.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1, d=16'hA55A, out_ready=1 -> out_valid=0, q=0, count=0, in_ready=0; after release, in_ready=1.
- Streaming: DEPTH=3, out_ready=1, in_valid=1, d=16'h0100,16'h0201,16'h0302 on consecutive edges -> same words on q on the 3rd, 4th and 5th edges after the first accept, out_valid=1 each cycle, count=3 steady.
- Stall and collapse: accept 16'h1111, idle 1 cycle, accept 16'h2222 with out_ready=0 -> words pack into stages 2 and 1, count=2. q=16'h1111 stays stable. in_ready stays 1 until count=3, then 0.
- Full simultaneous: pipe full (count=3), out_ready=1, in_valid=1, d=16'h4444 -> in_ready=1, oldest word leaves, count stays 3, 16'h4444 emerges 3 cycles later.
- Flush: count=3, assert flush one cycle with in_valid=1, d=16'h5555 -> next cycle count=0, out_valid=0, and 16'h5555 never appears on q.
- Reset over flush: reset=1 & flush=1 with pipe full -> all state cleared, q=0. After release, a new word 16'h6666 takes exactly DEPTH cycles to reach q.

Source files
------------

// File: rtl/flop_pipe.sv
// flop_pipe: CHANNELS x WIDTH lanes retimed through DEPTH valid-tracked stages
// with valid/ready backpressure, bubble collapsing, flush and occupancy count.
module flop_pipe #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DEPTH    = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [CHANNELS*WIDTH-1:0]     d,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CHANNELS*WIDTH-1:0]     q,
   output logic [$clog2(DEPTH+1)-1:0]    count
);

   localparam int unsigned DW = CHANNELS * WIDTH;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v;
   logic [DW-1:0]    r [DEPTH];
   logic [DEPTH-1:0] adv;
   logic             in_xfer;
   logic             out_xfer;

   // Advance chain from the output back; room means the stage above can take a word.
   always_comb begin
      logic room;
      adv  = '0;
      room = out_ready;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         adv[i] = v[i] & room;
         room   = room | ~v[i];
      end
   end

   // Input accepts when stage 0 is empty or emptying; blocked by reset and flush.
   assign in_ready  = ~reset & ~flush & (~v[0] | adv[0]);
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = adv[DEPTH-1];
   assign out_valid = v[DEPTH-1];
   assign q         = r[DEPTH-1];

   // Stage registers: data moves only together with its valid bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         v <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r[i] <= '0;
         end
      end else if (flush) begin
         v <= '0;
      end else begin
         for (int i = int'(DEPTH) - 1; i >= 1; i--) begin
            if (adv[i-1]) begin
               r[i] <= r[i-1];
               v[i] <= 1'b1;
            end else if (adv[i]) begin
               v[i] <= 1'b0;
            end
         end
         if (in_xfer) begin
            r[0] <= d;
            v[0] <= 1'b1;
         end else if (adv[0]) begin
            v[0] <= 1'b0;
         end
      end
   end

   // Occupancy tracks popcount(v): +1 on accept only, -1 on consume only.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         count <= '0;
      end else begin
         case ({in_xfer, out_xfer})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_flop_pipe.sv
// Directed vector bench for flop_pipe (WIDTH=8, CHANNELS=2, DEPTH=3).
module tb_flop_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] d;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] q;
   logic [1:0]  count;

   int n_vec = 0;
   int n_bad = 0;

   flop_pipe #(.WIDTH(8), .CHANNELS(2), .DEPTH(3)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready), .d(d), .out_valid(out_valid),
      .out_ready(out_ready), .q(q), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        fl;
      logic        iv;
      logic        ordy;
      logic [15:0] din;
      logic        e_ir;   // in_ready before the edge
      logic        e_ov;   // after the edge
      logic [15:0] e_q;
      logic [1:0]  e_cnt;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic rst, logic fl, logic iv, logic ordy,
                               logic [15:0] din, logic e_ir, logic e_ov,
                               logic [15:0] e_q, logic [1:0] e_cnt);
      vec_t t;
      t.rst = rst; t.fl = fl; t.iv = iv; t.ordy = ordy; t.din = din;
      t.e_ir = e_ir; t.e_ov = e_ov; t.e_q = e_q; t.e_cnt = e_cnt;
      return t;
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic fl, input logic iv,
                        input logic ordy, input logic [15:0] din);
      reset = rst; flush = fl; in_valid = iv; out_ready = ordy; d = din;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      drive(1'b1, 1'b0, 1'b1, 1'b1, 16'hA55A);

      //          rst  fl   iv   ordy d          ir   ov   q          cnt
      // reset held two cycles
      vq.push_back(mk(1, 0, 1, 1, 16'hA55A, 0, 0, 16'h0000, 2'd0));
      vq.push_back(mk(1, 0, 1, 1, 16'hA55A, 0, 0, 16'h0000, 2'd0));
      vq.push_back(mk(0, 0, 0, 1, 16'h0000, 1, 0, 16'h0000, 2'd0));
      // streaming, DEPTH cycles of latency, one word per cycle
      vq.push_back(mk(0, 0, 1, 1, 16'h0100, 1, 0, 16'h0000, 2'd1));
      vq.push_back(mk(0, 0, 1, 1, 16'h0201, 1, 0, 16'h0000, 2'd2));
      vq.push_back(mk(0, 0, 1, 1, 16'h0302, 1, 1, 16'h0100, 2'd3));
      vq.push_back(mk(0, 0, 1, 1, 16'h0403, 1, 1, 16'h0201, 2'd3));
      vq.push_back(mk(0, 0, 0, 1, 16'h0000, 1, 1, 16'h0302, 2'd2));
      vq.push_back(mk(0, 0, 0, 1, 16'h0000, 1, 1, 16'h0403, 2'd1));
      vq.push_back(mk(0, 0, 0, 1, 16'h0000, 1, 0, 16'h0403, 2'd0));
      // stall with bubble collapsing
      vq.push_back(mk(0, 0, 1, 0, 16'h1111, 1, 0, 16'h0403, 2'd1));
      vq.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0403, 2'd1));
      vq.push_back(mk(0, 0, 1, 0, 16'h2222, 1, 1, 16'h1111, 2'd2));
      vq.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h1111, 2'd2));
      vq.push_back(mk(0, 0, 1, 0, 16'h3333, 1, 1, 16'h1111, 2'd3));
      vq.push_back(mk(0, 0, 1, 0, 16'h3A3A, 0, 1, 16'h1111, 2'd3));
      // full pipe, simultaneous accept and consume
      vq.push_back(mk(0, 0, 1, 1, 16'h4444, 1, 1, 16'h2222, 2'd3));
      vq.push_back(mk(0, 0, 0, 1, 16'h0000, 1, 1, 16'h3333, 2'd2));
      vq.push_back(mk(0, 0, 0, 1, 16'h0000, 1, 1, 16'h4444, 2'd1));
      // refill then flush with an offered word
      vq.push_back(mk(0, 0, 1, 0, 16'h7777, 1, 1, 16'h4444, 2'd2));
      vq.push_back(mk(0, 0, 1, 0, 16'h8888, 1, 1, 16'h4444, 2'd3));
      vq.push_back(mk(0, 1, 1, 0, 16'h5555, 0, 0, 16'h4444, 2'd0));
      vq.push_back(mk(0, 0, 0, 1, 16'h0000, 1, 0, 16'h4444, 2'd0));
      vq.push_back(mk(0, 0, 0, 1, 16'h0000, 1, 0, 16'h4444, 2'd0));
      // refill then reset together with flush
      vq.push_back(mk(0, 0, 1, 0, 16'h9999, 1, 0, 16'h4444, 2'd1));
      vq.push_back(mk(0, 0, 1, 0, 16'hAAAA, 1, 0, 16'h4444, 2'd2));
      vq.push_back(mk(0, 0, 1, 0, 16'hBBBB, 1, 1, 16'h9999, 2'd3));
      vq.push_back(mk(1, 1, 1, 1, 16'hCCCC, 0, 0, 16'h0000, 2'd0));
      vq.push_back(mk(0, 0, 1, 1, 16'h6666, 1, 0, 16'h0000, 2'd1));
      vq.push_back(mk(0, 0, 0, 1, 16'h0000, 1, 0, 16'h0000, 2'd1));
      vq.push_back(mk(0, 0, 0, 1, 16'h0000, 1, 1, 16'h6666, 2'd1));

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].fl, vq[i].iv, vq[i].ordy, vq[i].din);
         #4;
         check("in_ready", i, 16'(in_ready), 16'(vq[i].e_ir));
         step();
         check("out_valid", i, 16'(out_valid), 16'(vq[i].e_ov));
         check("q", i, q, vq[i].e_q);
         check("count", i, 16'(count), 16'(vq[i].e_cnt));
      end

      // reset mid-stream discards in-flight words; next word takes full latency
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234);
      step();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h5678);
      step();
      check("mid_count_pre", 100, 16'(count), 16'd3);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      step();
      check("mid_count_rst", 101, 16'(count), 16'd0);
      check("mid_ov_rst", 102, 16'(out_valid), 16'd0);
      check("mid_q_rst", 103, q, 16'h0000);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hABCD);
      #4;
      check("mid_in_ready", 104, 16'(in_ready), 16'd1);
      step();
      lat = 1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      while (!out_valid && lat < 10) begin
         step();
         lat++;
      end
      check("mid_latency", 105, 16'(lat), 16'd3);
      check("mid_q", 106, q, 16'hABCD);
      step();
      check("mid_drain_ov", 107, 16'(out_valid), 16'd0);
      check("mid_drain_cnt", 108, 16'(count), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
